// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the serial pattern detector
// Contents:
//   state_t     - detector FSM states (IDLE: unconfigured, RUN: detecting)
//   len_width() - width needed to hold a pattern length 0..pat_w
//   DEF_CNT_W   - default match counter width
//   DEF_CNT_SAT - saturation value of a default-width match counter
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam int                   DEF_CNT_W   = 8;
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_SAT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/seq_det_sat_counter.sv
// rtl/seq_det_sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   inc        - count up by one this cycle (held at all-ones)
//   clear      - return to zero this cycle (wins over inc)
//   cnt        - current count
module seq_det_sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] SAT = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != SAT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector
// Build option: SEQDET_OUT_REG_EN registers detect (one cycle after the final bit).
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   cfg_load    - latch pat / pat_len / overlap_en this cycle
//   pat         - pattern, pat[pat_len-1] oldest bit, pat[0] newest
//   pat_len     - active pattern length, legal 1..PAT_W
//   overlap_en  - 1 = overlapping matches, 0 = non-overlapping
//   in_valid    - in_bit qualifier
//   in_bit      - serial data
//   detect      - match pulse (same cycle as the final bit by default)
//   match_cnt   - saturating count of matches
//   cfg_err     - one-cycle pulse after a cfg_load with an illegal pat_len
//   armed       - detector configured (RUN)
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LEN_W = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err,
    output logic             armed
);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PAT_W-1:0] hist_ext;
    logic [PAT_W-1:0] len_mask;
    logic             cfg_legal;
    logic             accept;
    logic             fill_ok;
    logic             pat_hit;
    logic             det_raw;

    // Window of the last PAT_W bits including the one arriving now.
    assign hist_ext = {hist_q, in_bit};

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign cfg_legal = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
    assign accept    = in_valid && !cfg_load && (state_q == RUN);
    // fill >= len-1, written as fill+1 >= len so len never underflows.
    assign fill_ok   = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
    assign pat_hit   = (((hist_ext ^ pat_q) & len_mask) == '0);
    assign det_raw   = accept && fill_ok && pat_hit;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;
        if (cfg_load) begin
            // A load always takes priority; any same-cycle bit is dropped.
            if (cfg_legal) begin
                state_d = RUN;
                pat_d   = pat;
                len_d   = pat_len;
                ovl_d   = overlap_en;
                hist_d  = '0;
                fill_d  = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (accept) begin
            if (det_raw && !ovl_q) begin
                // Non-overlap: discard every bit of the matched window.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_ext[PAT_W-2:0];
                if (fill_q != LEN_W'(PAT_W)) begin
                    fill_d = fill_q + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef SEQDET_OUT_REG_EN
    logic detect_q;
    logic detect_d;

    assign detect_d = det_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            detect_q <= 1'b0;
        end else begin
            detect_q <= detect_d;
        end
    end

    assign detect = detect_q;
`else
    assign detect = det_raw;
`endif

    seq_det_sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (det_raw),
        .clear(1'b0),
        .cnt  (match_cnt)
    );

    assign cfg_err = cfg_err_q;
    assign armed   = (state_q == RUN);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_load;
    logic [7:0] pat;
    logic [3:0] pat_len;
    logic       overlap_en;
    logic       in_valid;
    logic       in_bit;

    logic       detect;
    logic [7:0] match_cnt;
    logic       cfg_err;
    logic       armed;

    logic       detect2;
    logic [1:0] match_cnt2;
    logic       cfg_err2;
    logic       armed2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .overlap_en(overlap_en), .in_valid(in_valid), .in_bit(in_bit),
        .detect(detect), .match_cnt(match_cnt), .cfg_err(cfg_err), .armed(armed)
    );

    seq_pattern_detector #(.PAT_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .overlap_en(overlap_en), .in_valid(in_valid), .in_bit(in_bit),
        .detect(detect2), .match_cnt(match_cnt2), .cfg_err(cfg_err2), .armed(armed2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; Mealy detect is checked
    // mid-cycle, then the clock edge consumes the bit.
    task automatic send(input logic b, input logic exp_det, input string tag);
        in_valid = 1'b1;
        in_bit   = b;
        #4;
        check(tag, 32'(detect), 32'(exp_det));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_load   = 1'b1;
        pat        = p;
        pat_len    = l;
        overlap_en = ov;
        #4;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_load   = 1'b0;
        pat        = '0;
        pat_len    = '0;
        overlap_en = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        #2;
        check("rst_detect", 32'(detect), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_armed", 32'(armed), 0);
        do_reset();

        // 1: unconfigured block ignores input
        send(1'b1, 1'b0, "idle_b1");
        send(1'b1, 1'b0, "idle_b2");
        send(1'b1, 1'b0, "idle_b3");
        check("idle_armed", 32'(armed), 0);
        check("idle_cnt", 32'(match_cnt), 0);

        // 2: overlap mode, pattern 1011
        cfg(8'b0000_1011, 4'd4, 1'b1);
        check("ov_armed", 32'(armed), 1);
        check("ov_cfg_err", 32'(cfg_err), 0);
        send(1'b1, 1'b0, "ov_b1");
        send(1'b0, 1'b0, "ov_b2");
        send(1'b1, 1'b0, "ov_b3");
        send(1'b1, 1'b1, "ov_b4");
        send(1'b0, 1'b0, "ov_b5");
        send(1'b1, 1'b0, "ov_b6");
        send(1'b1, 1'b1, "ov_b7");
        check("ov_cnt", 32'(match_cnt), 2);

        // 3: non-overlap mode, fresh from reset
        do_reset();
        check("rst2_armed", 32'(armed), 0);
        check("rst2_cnt", 32'(match_cnt), 0);
        cfg(8'b0000_1011, 4'd4, 1'b0);
        send(1'b1, 1'b0, "no_b1");
        send(1'b0, 1'b0, "no_b2");
        send(1'b1, 1'b0, "no_b3");
        send(1'b1, 1'b1, "no_b4");
        send(1'b0, 1'b0, "no_b5");
        send(1'b1, 1'b0, "no_b6");
        send(1'b1, 1'b0, "no_b7");
        check("no_cnt", 32'(match_cnt), 1);

        // 4: illegal lengths are rejected and leave the configuration intact
        cfg(8'hFF, 4'd0, 1'b1);
        check("len0_cfg_err", 32'(cfg_err), 1);
        check("len0_armed", 32'(armed), 1);
        @(posedge clk);
        #1;
        check("len0_err_clear", 32'(cfg_err), 0);
        cfg(8'hFF, 4'd9, 1'b1);
        check("len9_cfg_err", 32'(cfg_err), 1);
        check("len9_armed", 32'(armed), 1);
        @(posedge clk);
        #1;
        check("len9_err_clear", 32'(cfg_err), 0);
        send(1'b1, 1'b0, "keep_b1");
        send(1'b0, 1'b0, "keep_b2");
        send(1'b1, 1'b0, "keep_b3");
        send(1'b1, 1'b1, "keep_b4");
        send(1'b0, 1'b0, "keep_b5");
        send(1'b1, 1'b0, "keep_b6");
        send(1'b1, 1'b0, "keep_b7");
        check("keep_cnt", 32'(match_cnt), 2);

        // 6: cfg_load beats a same-cycle bit and clears history
        cfg(8'b0000_1011, 4'd4, 1'b1);
        send(1'b1, 1'b0, "mid_b1");
        send(1'b0, 1'b0, "mid_b2");
        send(1'b1, 1'b0, "mid_b3");
        cfg_load   = 1'b1;
        in_valid   = 1'b1;
        in_bit     = 1'b1;
        #4;
        check("mid_cfg_detect", 32'(detect), 0);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        send(1'b1, 1'b0, "post_b1");
        send(1'b0, 1'b0, "post_b2");
        send(1'b1, 1'b0, "post_b3");
        send(1'b1, 1'b1, "post_b4");
        check("post_cnt", 32'(match_cnt), 3);
        send(1'b0, 1'b0, "pre_rst_b1");
        send(1'b1, 1'b0, "pre_rst_b2");
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #2;
        check("pre_rst_detect", 32'(detect), 1);
        reset = 1'b1;
        #1;
        check("async_detect", 32'(detect), 0);
        check("async_cnt", 32'(match_cnt), 0);
        check("async_armed", 32'(armed), 0);
        check("async_cfg_err", 32'(cfg_err), 0);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 5: length-1 pattern, 2-bit counter saturates
        cfg(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            #4;
            check($sformatf("len1_det2_%0d", i), 32'(detect2), 1);
            @(posedge clk);
            #1;
            check($sformatf("len1_cnt2_%0d", i), 32'(match_cnt2), (i < 3) ? i + 1 : 3);
        end
        in_valid = 1'b0;
        check("len1_cnt8", 32'(match_cnt), 6);
        send(1'b0, 1'b0, "len1_zero");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
